// File: rtl/lc3_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_button_ctrl
// Description : LC-3 front-panel Run/Continue responder. Each button goes
//               through a synchronizer and a debounce filter. A press that
//               survives the filter becomes a one-cycle Start or Resume
//               pulse, depending on where the run-state FSM is.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run_n,
    input  logic       Continue_n,
    input  logic       Pause_req,
    input  logic       Halt,
    output logic       Start,
    output logic       Resume,
    output logic       Running,
    output logic       Paused,
    output logic [1:0] State
);

    localparam int                 c_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter value at which one more differing sample is accepted.
    localparam logic [c_CNT_W-1:0] c_ACCEPT = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_PAUSED   = 2'b10,
        ST_RESUMING = 2'b11
    } state_t;

    // Bit 0 is Run, bit 1 is Continue.
    logic [1:0] w_raw;
    logic [1:0] w_press;
    logic       r_live;

    assign w_raw = {Continue_n, Run_n};

    // r_live goes high on the first edge after reset. From then on, sync
    // stage 1 holds a real sample, so a button held through reset cannot
    // arm its channel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_deb;
        logic               r_armed;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_accept;

        // The debounced level flips on the edge that sees the
        // DEBOUNCE_CYCLES-th consecutive differing sample.
        assign w_accept   = (r_sync2 != r_deb) && (r_cnt == c_ACCEPT);
        assign w_press[i] = w_accept && !r_sync2 && r_armed;

        // Synchronizer, debounce counter and debounced level.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_deb   <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[i];
                r_sync2 <= r_sync1;
                if (r_sync2 != r_deb) begin
                    if (w_accept) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // The armed flag allows one event per press. It re-arms only after
        // a real release.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_armed <= 1'b0;
            end else if (w_press[i]) begin
                r_armed <= 1'b0;
            end else if (r_live && r_deb && r_sync1) begin
                r_armed <= 1'b1;
            end
        end
    end

    state_t r_state;
    state_t w_state_nxt;
    logic   r_start;
    logic   r_resume;
    logic   w_start_nxt;
    logic   w_resume_nxt;

    // Next-state and pulse decode. Halt outranks pause and press events
    // everywhere except IDLE. Any press that is not used here is lost.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_nxt  = 1'b0;
        w_resume_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[0]) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (Halt) begin
                    w_state_nxt = ST_IDLE;
                end else if (Pause_req) begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (Halt) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_press[1]) begin
                    w_resume_nxt = 1'b1;
                    w_state_nxt  = ST_RESUMING;
                end
            end
            ST_RESUMING: begin
                if (Halt) begin
                    w_state_nxt = ST_IDLE;
                end else if (!Pause_req) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered command pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_start  <= 1'b0;
            r_resume <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_start  <= w_start_nxt;
            r_resume <= w_resume_nxt;
        end
    end

    assign State   = r_state;
    assign Start   = r_start;
    assign Resume  = r_resume;
    assign Running = (r_state == ST_RUNNING) || (r_state == ST_RESUMING);
    assign Paused  = (r_state == ST_PAUSED);

endmodule
`default_nettype wire
